// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared types and widths for the bf16 MAC vector sequencer
package mac_seq_pkg;

    localparam int IDX_W_DEF   = 11;
    localparam int TIMEOUT_DEF = 64;
    localparam int BF16_W      = 16;
    localparam int FP32_W      = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mac_seq_watchdog.sv
// rtl/mac_seq_watchdog.sv - cycle counter that flags the TIMEOUT-th enabled cycle since clear
module mac_seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // expired is high during the TIMEOUT-th enabled cycle after clear; the count then holds
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mac_vec_sequencer.sv
// rtl/mac_vec_sequencer.sv - fetch/issue/wait/compare sequencer for the bf16 MAC (option: MAC_SEQ_FAIL_CAPTURE_EN)
module mac_vec_sequencer
    import mac_seq_pkg::*;
#(
    parameter int IDX_W   = IDX_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [IDX_W-1:0]  num_vec,
    output logic [IDX_W-1:0]  vec_addr,
    input  logic [BF16_W-1:0] vec_a,
    input  logic [BF16_W-1:0] vec_b,
    input  logic [FP32_W-1:0] vec_c,
    input  logic [FP32_W-1:0] vec_exp,
    output logic [BF16_W-1:0] mac_a,
    output logic [BF16_W-1:0] mac_b,
    output logic [FP32_W-1:0] mac_c,
    output logic              EN_mac,
    input  logic              RDY_mac,
    input  logic [FP32_W-1:0] mac_result,
    input  logic              mac_valid,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  pass_cnt,
    output logic [IDX_W-1:0]  fail_cnt,
    output logic              timeout_err
`ifdef MAC_SEQ_FAIL_CAPTURE_EN
    ,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [FP32_W-1:0] first_fail_got,
    output logic [FP32_W-1:0] first_fail_exp
`endif
);

    state_t state, state_nx;

    logic [IDX_W-1:0]  num_lat;
    logic [IDX_W-1:0]  idx;
    logic [FP32_W-1:0] exp_r;

    logic accept;
    logic xfer;
    logic resp;
    logic abort;
    logic last;
    logic match;
    logic wd_expired;

    assign last     = (idx == num_lat - IDX_W'(1));
    assign match    = (mac_result == exp_r);
    assign vec_addr = idx;
    assign EN_mac   = (state == ISSUE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        xfer     = 1'b0;
        resp     = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (num_vec == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_nx = LOAD;
            LOAD:  state_nx = ISSUE;
            ISSUE: begin
                if (RDY_mac) begin
                    xfer     = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                // a result arriving in the final watchdog cycle still counts
                if (mac_valid) begin
                    resp     = 1'b1;
                    state_nx = last ? DONE : FETCH;
                end else if (wd_expired) begin
                    abort    = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    mac_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear   (xfer),
        .enable  (state == WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            num_lat     <= '0;
            idx         <= '0;
            mac_a       <= '0;
            mac_b       <= '0;
            mac_c       <= '0;
            exp_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                num_lat     <= num_vec;
                idx         <= '0;
                pass_cnt    <= '0;
                fail_cnt    <= '0;
                timeout_err <= 1'b0;
                done        <= 1'b0;
                busy        <= 1'b1;
            end else if (state == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            // memory data for vec_addr lands during LOAD
            if (state == LOAD) begin
                mac_a <= vec_a;
                mac_b <= vec_b;
                mac_c <= vec_c;
                exp_r <= vec_exp;
            end
            if (resp) begin
                if (match) begin
                    if (~&pass_cnt) pass_cnt <= pass_cnt + IDX_W'(1);
                end else begin
                    if (~&fail_cnt) fail_cnt <= fail_cnt + IDX_W'(1);
                end
                if (!last) idx <= idx + IDX_W'(1);
            end
            if (abort) timeout_err <= 1'b1;
        end
    end

`ifdef MAC_SEQ_FAIL_CAPTURE_EN
    logic captured;

    always_ff @(posedge CLK) begin
        if (!RST_N || accept) begin
            captured       <= 1'b0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            first_fail_exp <= '0;
        end else if (resp && !match && !captured) begin
            captured       <= 1'b1;
            first_fail_idx <= idx;
            first_fail_got <= mac_result;
            first_fail_exp <= exp_r;
        end
    end
`endif

endmodule

// File: tb/tb_mac_vec_sequencer.sv
// tb/tb_mac_vec_sequencer.sv - randomized self-checking bench for mac_vec_sequencer with MAC/memory models
module tb_mac_vec_sequencer;

    localparam int IDX_W   = 11;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             start;
    logic [IDX_W-1:0] num_vec;
    logic [IDX_W-1:0] vec_addr;
    logic [15:0]      vec_a, vec_b, mac_a, mac_b;
    logic [31:0]      vec_c, vec_exp, mac_c, mac_result;
    logic             en_mac, rdy_mac, mac_valid;
    logic             busy, done, timeout_err;
    logic [IDX_W-1:0] pass_cnt, fail_cnt;
`ifdef MAC_SEQ_FAIL_CAPTURE_EN
    logic [IDX_W-1:0] first_fail_idx;
    logic [31:0]      first_fail_got, first_fail_exp;
`endif

    mac_vec_sequencer #(
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .start       (start),
        .num_vec     (num_vec),
        .vec_addr    (vec_addr),
        .vec_a       (vec_a),
        .vec_b       (vec_b),
        .vec_c       (vec_c),
        .vec_exp     (vec_exp),
        .mac_a       (mac_a),
        .mac_b       (mac_b),
        .mac_c       (mac_c),
        .EN_mac      (en_mac),
        .RDY_mac     (rdy_mac),
        .mac_result  (mac_result),
        .mac_valid   (mac_valid),
        .busy        (busy),
        .done        (done),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt),
        .timeout_err (timeout_err)
`ifdef MAC_SEQ_FAIL_CAPTURE_EN
        ,
        .first_fail_idx (first_fail_idx),
        .first_fail_got (first_fail_got),
        .first_fail_exp (first_fail_exp)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // vector memory: registered read, one cycle latency
    logic [15:0] mem_a [0:2047];
    logic [15:0] mem_b [0:2047];
    logic [31:0] mem_c [0:2047];
    logic [31:0] mem_e [0:2047];

    always @(posedge clk) begin
        vec_a   <= mem_a[vec_addr];
        vec_b   <= mem_b[vec_addr];
        vec_c   <= mem_c[vec_addr];
        vec_exp <= mem_e[vec_addr];
    end

    // per-run plan for the MAC model: latency in WAIT cycles (NEVER = no reply) and result corruption
    int          lat_tab  [0:63];
    logic [31:0] flip_tab [0:63];
    int          hold_n   = 0;
    int          run_id   = 0;
    bit          spur_en  = 1'b0;
    bit          rdy_rand = 1'b0;

    // MAC model; xfer_cnt = operand transfers accepted in the current run
    int seen_run = 0;
    int xfer_cnt = 0;
    int hold_left = 0;
    int cd = 0;
    bit outstanding = 1'b0;

    initial begin
        rdy_mac    = 1'b0;
        mac_valid  = 1'b0;
        mac_result = '0;
        forever begin
            @(negedge clk);
            #1;
            if (run_id != seen_run) begin
                seen_run    = run_id;
                xfer_cnt    = 0;
                hold_left   = hold_n;
                outstanding = 1'b0;
            end
            if (!busy) outstanding = 1'b0;
            mac_valid = 1'b0;
            if (outstanding) begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        mac_valid   = 1'b1;
                        mac_result  = mem_e[xfer_cnt-1] ^ flip_tab[xfer_cnt-1];
                        outstanding = 1'b0;
                    end
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                mac_valid  = 1'b1;
                mac_result = $urandom;
            end
            if (en_mac && hold_left > 0) begin
                rdy_mac = 1'b0;
                hold_left--;
            end else begin
                rdy_mac = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (en_mac && rdy_mac) begin
                outstanding = 1'b1;
                cd          = lat_tab[xfer_cnt];
                xfer_cnt++;
            end
        end
    end

    // expected outcome of a run, from the plan alone
    int exp_issues = 0;
    int e_pass, e_fail, e_to;

    task automatic model(input int nv);
        e_pass = 0;
        e_fail = 0;
        e_to   = 0;
        exp_issues = 0;
        for (int k = 0; k < nv; k++) begin
            exp_issues = k + 1;
            if (lat_tab[k] == NEVER || lat_tab[k] > TIMEOUT) begin
                e_to = 1;
                break;
            end
            if (flip_tab[k] != 0) e_fail++;
            else e_pass++;
        end
    endtask

    // every issue cycle: operands must be exactly the vector currently being issued
    int en_total = 0;
    always @(negedge clk) begin
        if (rst_n && en_mac) begin
            en_total++;
            check("issue_within_run", 64'(xfer_cnt < exp_issues), 64'd1);
            if (xfer_cnt < exp_issues) begin
                check("vec_addr", 64'(vec_addr), 64'(xfer_cnt));
                check("mac_a", 64'(mac_a), 64'(mem_a[xfer_cnt]));
                check("mac_b", 64'(mac_b), 64'(mem_b[xfer_cnt]));
                check("mac_c", 64'(mac_c), 64'(mem_c[xfer_cnt]));
            end
        end
    end

    task automatic fill(input int nv, input int lat);
        for (int k = 0; k < 64; k++) begin
            mem_a[k]    = 16'($urandom);
            mem_b[k]    = 16'($urandom);
            mem_c[k]    = $urandom;
            mem_e[k]    = $urandom;
            lat_tab[k]  = lat;
            flip_tab[k] = '0;
        end
        hold_n = 0;
    endtask

    task automatic start_run(input int nv);
        @(negedge clk);
        model(nv);
        run_id++;
        start   = 1'b1;
        num_vec = IDX_W'(nv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_xfer(input int n);
        int t = 0;
        while (xfer_cnt < n && t < 1000) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("xfer_reached", 64'(xfer_cnt >= n), 64'd1);
    endtask

    task automatic finish_run(input int budget);
        int t = 0;
        while (done !== 1'b1 && t < budget) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("done", 64'(done), 64'd1);
        check("busy_end", 64'(busy), 64'd0);
        check("pass_cnt", 64'(pass_cnt), 64'(e_pass));
        check("fail_cnt", 64'(fail_cnt), 64'(e_fail));
        check("timeout_err", 64'(timeout_err), 64'(e_to));
        check("transfers", 64'(xfer_cnt), 64'(exp_issues));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_outs"}, {vec_addr, mac_a, mac_b, 5'd0, en_mac, busy, done, timeout_err}, 64'd0);
        check({tag, "_mac_c"}, 64'(mac_c), 64'd0);
        check({tag, "_counts"}, {pass_cnt, fail_cnt}, 64'd0);
`ifdef MAC_SEQ_FAIL_CAPTURE_EN
        check({tag, "_ffail"}, {first_fail_idx, first_fail_got}, 64'd0);
`endif
    endtask

    initial begin
        int n;
        int nv;
        int en0;
        rst_n   = 1'b0;
        start   = 1'b0;
        num_vec = '0;
        fill(0, 3);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // four vectors, reply 3 cycles after issue
        fill(4, 3);
        start_run(4);
        finish_run(300);
        check("t1_pass_lit", 64'(pass_cnt), 64'd4);
        check("t1_fail_lit", 64'(fail_cnt), 64'd0);

        // vector 1 corrupted in bit 0
        fill(3, 3);
        flip_tab[1] = 32'h1;
        start_run(3);
        finish_run(300);
        check("t2_pass_lit", 64'(pass_cnt), 64'd2);
        check("t2_fail_lit", 64'(fail_cnt), 64'd1);
`ifdef MAC_SEQ_FAIL_CAPTURE_EN
        check("t2_ffail_idx", 64'(first_fail_idx), 64'd1);
        check("t2_ffail_got", 64'(first_fail_got), 64'(mem_e[1] ^ 32'h1));
        check("t2_ffail_exp", 64'(first_fail_exp), 64'(mem_e[1]));
`endif

        // RDY_mac withheld 5 cycles on vector 0: 6 issue cycles, one transfer
        fill(1, 2);
        hold_n = 5;
        en0 = en_total;
        start_run(1);
        finish_run(300);
        check("t3_en_cycles", 64'(en_total - en0), 64'd6);

        // no reply: abort after 64 WAIT cycles, done two cycles later
        fill(2, 3);
        lat_tab[0] = NEVER;
        start_run(2);
        wait_xfer(1);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_done_cycle", 64'(n), 64'd66);
        finish_run(10);
        check("t4_timeout_lit", 64'(timeout_err), 64'd1);

        // reply in the last watchdog cycle counts; one cycle later does not
        fill(2, 64);
        lat_tab[1] = TIMEOUT + 1;
        start_run(2);
        finish_run(400);
        check("t5_pass_lit", 64'(pass_cnt), 64'd1);
        check("t5_to_lit", 64'(timeout_err), 64'd1);

        // empty run
        fill(0, 3);
        en0 = en_total;
        start_run(0);
        check("t6_busy_c1", {busy, done}, 64'b10);
        @(negedge clk);
        check("t6_done_c2", {busy, done}, 64'b01);
        finish_run(10);
        check("t6_no_issue", 64'(en_total - en0), 64'd0);

        // start while busy is ignored
        fill(5, 2);
        start_run(5);
        wait_xfer(1);
        @(negedge clk);
        start   = 1'b1;
        num_vec = IDX_W'(9);
        @(negedge clk);
        start = 1'b0;
        finish_run(400);
        check("t7_pass_lit", 64'(pass_cnt), 64'd5);

        // reset in WAIT, then a clean run
        fill(3, 3);
        lat_tab[0] = NEVER;
        start_run(3);
        wait_xfer(1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("t8_reset");
        rst_n = 1'b1;
        fill(3, 4);
        start_run(3);
        finish_run(300);
        check("t8_pass_lit", 64'(pass_cnt), 64'd3);

        // randomized runs with ready stalls, stray mac_valid and mixed outcomes
        spur_en  = 1'b1;
        rdy_rand = 1'b1;
        for (int r = 0; r < 25; r++) begin
            nv = $urandom_range(1, 12);
            fill(nv, 1);
            for (int k = 0; k < nv; k++) begin
                case ($urandom_range(0, 19))
                    0:       lat_tab[k] = NEVER;
                    1:       lat_tab[k] = $urandom_range(60, 66);
                    default: lat_tab[k] = $urandom_range(1, 8);
                endcase
                if ($urandom_range(0, 3) == 0) flip_tab[k] = 32'h1 << $urandom_range(0, 31);
            end
            start_run(nv);
            finish_run((nv + 1) * 150);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        n_bad++;
        $display("FAIL global_time_limit: simulation still running at t=%0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $fatal(1, "time limit");
    end

endmodule
